// File: rtl/data_gen_stream.sv
// Deterministic 32-bit word source: ap_ctrl_hs start/done handshake, ap_hs (vld/ack) output.
// Emits NUM_WORDS words per run, either an incrementing sequence or a Galois LFSR sequence.
module data_gen_stream #(
  parameter int unsigned NUM_WORDS = 4096,
  parameter int unsigned MODE      = 0,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter logic [31:0] STEP      = 32'h0000_0001
) (
  input  logic        ap_clk,
  input  logic        reset_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack,
  output logic [1:0]  dbg_state_o
);

  // Output stream handshake: a word moves when Output_1_V_V_ap_vld and
  // Output_1_V_V_ap_ack are both high at a rising edge; while vld is high and
  // ack is low, data and vld hold; ack with vld low has no effect.

  localparam int unsigned       CW   = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0]     LAST = CW'(NUM_WORDS - 1);
  localparam logic [31:0]       POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pat_q, pat_d;
  logic [31:0]     data_q, data_d;
  logic            vld_q, vld_d;
  logic            xfer;

  function automatic logic [31:0] next_word(input logic [31:0] w);
    if (MODE == 1) return (w >> 1) ^ ({32{w[0]}} & POLY);
    else           return w + STEP;
  endfunction

  assign xfer = vld_q & Output_1_V_V_ap_ack;

  // pat_q always holds the word that follows the one currently presented.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    data_d  = data_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d = RUN;
          data_d  = SEED;
          pat_d   = next_word(SEED);
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (cnt_q == LAST) begin
            vld_d   = 1'b0;
            state_d = DONE;
            pat_d   = SEED;
          end else begin
            data_d = pat_q;
            pat_d  = next_word(pat_q);
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= SEED;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign ap_idle             = (state_q == IDLE);
  assign ap_done             = (state_q == DONE);
  assign ap_ready            = (state_q == DONE);
  assign Output_1_V_V        = data_q;
  assign Output_1_V_V_ap_vld = vld_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_data_gen_stream.sv
// Directed bench for data_gen_stream: four instances cover the short incrementing run,
// the 4096-word LFSR run, a wrapping increment and the single-word run.
module tb_data_gen_stream;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // dut0: NUM_WORDS=8, MODE 0, SEED=0x10, STEP=1
  logic        start0 = 0, ack0 = 0, done0, idle0, ready0, vld0;
  logic [31:0] data0;
  logic [1:0]  st0;
  // dut1: NUM_WORDS=4096, MODE 1, SEED=1
  logic        start1 = 0, ack1 = 0, done1, idle1, ready1, vld1;
  logic [31:0] data1;
  logic [1:0]  st1;
  // dut2: NUM_WORDS=3, MODE 0, SEED=0xFFFFFFFE, STEP=2 (wraps)
  logic        start2 = 0, ack2 = 0, done2, idle2, ready2, vld2;
  logic [31:0] data2;
  logic [1:0]  st2;
  // dut3: NUM_WORDS=1, MODE 0, SEED=0xA5A5A5A5
  logic        start3 = 0, ack3 = 0, done3, idle3, ready3, vld3;
  logic [31:0] data3;
  logic [1:0]  st3;

  data_gen_stream #(.NUM_WORDS(8), .MODE(0), .SEED(32'h10), .STEP(32'h1)) dut0 (
    .ap_clk(clk), .reset_n(reset_n), .ap_start(start0), .ap_done(done0), .ap_idle(idle0),
    .ap_ready(ready0), .Output_1_V_V(data0), .Output_1_V_V_ap_vld(vld0),
    .Output_1_V_V_ap_ack(ack0), .dbg_state_o(st0));
  data_gen_stream #(.NUM_WORDS(4096), .MODE(1), .SEED(32'h1), .STEP(32'h1)) dut1 (
    .ap_clk(clk), .reset_n(reset_n), .ap_start(start1), .ap_done(done1), .ap_idle(idle1),
    .ap_ready(ready1), .Output_1_V_V(data1), .Output_1_V_V_ap_vld(vld1),
    .Output_1_V_V_ap_ack(ack1), .dbg_state_o(st1));
  data_gen_stream #(.NUM_WORDS(3), .MODE(0), .SEED(32'hFFFF_FFFE), .STEP(32'h2)) dut2 (
    .ap_clk(clk), .reset_n(reset_n), .ap_start(start2), .ap_done(done2), .ap_idle(idle2),
    .ap_ready(ready2), .Output_1_V_V(data2), .Output_1_V_V_ap_vld(vld2),
    .Output_1_V_V_ap_ack(ack2), .dbg_state_o(st2));
  data_gen_stream #(.NUM_WORDS(1), .MODE(0), .SEED(32'hA5A5_A5A5), .STEP(32'h1)) dut3 (
    .ap_clk(clk), .reset_n(reset_n), .ap_start(start3), .ap_done(done3), .ap_idle(idle3),
    .ap_ready(ready3), .Output_1_V_V(data3), .Output_1_V_V_ap_vld(vld3),
    .Output_1_V_V_ap_ack(ack3), .dbg_state_o(st3));

  // Inputs are driven and outputs sampled at the falling edge; the value of ack
  // seen here is the one the next rising edge will act on.
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({idle0, vld0, done0, ready0} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got idle/vld/done/ready=%b expected 1000", {idle0, vld0, done0, ready0});
    end
    n_checks++;
    if (data0 !== 32'h0 || st0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_data_state: got data=%h st=%0d expected 0/0", data0, st0);
    end
    n_checks++;
    if ({vld1, vld2, vld3, idle1, idle2, idle3} !== 6'b000111) begin
      n_fail++; $display("FAIL reset_others: got %b expected 000111", {vld1, vld2, vld3, idle1, idle2, idle3});
    end
    ack0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (vld0 !== 1'b0 || idle0 !== 1'b1 || done0 !== 1'b0) begin
        n_fail++; $display("FAIL idle_no_output: cycle %0d got vld=%b idle=%b done=%b expected 0/1/0", c, vld0, idle0, done0);
      end
    end
    ack0 = 1'b0;
  endtask

  task automatic test_full_rate();
    @(negedge clk); start0 = 1'b1; ack0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (vld0 !== 1'b1 || data0 !== 32'h10 + 32'(i) || done0 !== 1'b0) begin
        n_fail++; $display("FAIL full_rate_word%0d: got vld=%b data=%h done=%b expected 1/%h/0", i, vld0, data0, done0, 32'h10 + 32'(i));
      end
      @(negedge clk);
    end
    n_checks++;
    if ({vld0, done0, ready0, idle0} !== 4'b0110 || st0 !== 2'd2) begin
      n_fail++; $display("FAIL full_rate_done: got vld/done/ready/idle=%b st=%0d expected 0110 st=2", {vld0, done0, ready0, idle0}, st0);
    end
    @(negedge clk);
    n_checks++;
    if ({done0, ready0, idle0} !== 3'b001) begin
      n_fail++; $display("FAIL full_rate_idle: got done/ready/idle=%b expected 001", {done0, ready0, idle0});
    end
    ack0 = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit done_seen = 0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h10 + 32'(k));
    @(negedge clk); start0 = 1'b1; ack0 = 1'b0;
    @(negedge clk); start0 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      n_checks++;
      if (vld0 !== 1'b1 || data0 !== 32'h10) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d got vld=%b data=%h expected 1/00000010", c, vld0, data0);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 60 && !done_seen; c++) begin
      ack0 = ~ack0;
      if (vld0 && ack0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_word: got %h expected no word", data0);
        end else if (data0 !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_word: got %h expected %h", data0, exp_q[0]);
          void'(exp_q.pop_front());
        end else void'(exp_q.pop_front());
      end
      if (done0) done_seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!done_seen || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_complete: got done=%b left=%0d expected done=1 left=0", done_seen, exp_q.size());
    end
    ack0 = 1'b0;
  endtask

  task automatic test_lfsr();
    logic [31:0] w = 32'h1;
    logic [31:0] hand [3];
    int k = 0;
    bit done_seen = 0;
    hand[0] = 32'h0000_0001; hand[1] = 32'h8020_0003; hand[2] = 32'hC030_0002;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) begin
      exp_q.push_back(w);
      if (w[0]) w = (w >> 1) ^ 32'h8020_0003;
      else      w = w >> 1;
    end
    @(negedge clk); start1 = 1'b1; ack1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 4200 && !done_seen; c++) begin
      if (vld1 && ack1) begin
        if (k < 3) begin
          n_checks++;
          if (data1 !== hand[k]) begin
            n_fail++; $display("FAIL lfsr_hand%0d: got %h expected %h", k, data1, hand[k]);
          end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL lfsr_extra: got %h expected no word", data1);
        end else begin
          if (data1 !== exp_q[0]) begin
            n_fail++; $display("FAIL lfsr_word%0d: got %h expected %h", k, data1, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        k++;
      end
      if (done1) done_seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!done_seen || k != 4096) begin
      n_fail++; $display("FAIL lfsr_count: got done=%b words=%0d expected 1/4096", done_seen, k);
    end
    ack1 = 1'b0;
  endtask

  task automatic test_held_start();
    int dones = 0;
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) exp_q.push_back(32'h10 + 32'(k));
    @(negedge clk);
    ack0 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 0)  start0 = 1'b1;
      if (c == 11) start0 = 1'b0;
      if (c == 10) begin
        n_checks++;
        if (idle0 !== 1'b1) begin
          n_fail++; $display("FAIL held_idle_gap: got idle=%b expected 1", idle0);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (vld0 !== 1'b1 || data0 !== 32'h10) begin
          n_fail++; $display("FAIL held_restart: got vld=%b data=%h expected 1/00000010", vld0, data0);
        end
      end
      if (vld0 && ack0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL held_extra: got %h expected no word", data0);
        end else begin
          if (data0 !== exp_q[0]) begin
            n_fail++; $display("FAIL held_word: got %h expected %h", data0, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (done0) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 2 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL held_summary: got dones=%0d left=%0d expected 2/0", dones, exp_q.size());
    end
    ack0 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    @(negedge clk); start0 = 1'b1; ack0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (data0 !== 32'h14 || vld0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_word4: got vld=%b data=%h expected 1/00000014", vld0, data0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({vld0, idle0, done0} !== 3'b010 || data0 !== 32'h0 || st0 !== 2'd0) begin
      n_fail++; $display("FAIL mid_abort: got vld/idle/done=%b data=%h st=%0d expected 010/0/0", {vld0, idle0, done0}, data0, st0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (done0) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", dones);
    end
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n_checks++;
    if (vld0 !== 1'b1 || data0 !== 32'h10) begin
      n_fail++; $display("FAIL mid_restart: got vld=%b data=%h expected 1/00000010", vld0, data0);
    end
    repeat (10) @(negedge clk);
    ack0 = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] ack_pat = 8'b1011_0100;
    bit done_seen = 0;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0002);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      ack2 = ack_pat[c % 8];
      if (vld2 && ack2) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL wrap_extra: got %h expected no word", data2);
        end else begin
          if (data2 !== exp_q[0]) begin
            n_fail++; $display("FAIL wrap_word: got %h expected %h", data2, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (done2) done_seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!done_seen || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_complete: got done=%b left=%0d expected 1/0", done_seen, exp_q.size());
    end
    ack2 = 1'b0;
  endtask

  task automatic test_single_word();
    @(negedge clk); start3 = 1'b1; ack3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    n_checks++;
    if (vld3 !== 1'b1 || data3 !== 32'hA5A5_A5A5 || done3 !== 1'b0) begin
      n_fail++; $display("FAIL single_word: got vld=%b data=%h done=%b expected 1/a5a5a5a5/0", vld3, data3, done3);
    end
    @(negedge clk);
    n_checks++;
    if ({vld3, done3, ready3, idle3} !== 4'b0110) begin
      n_fail++; $display("FAIL single_done: got vld/done/ready/idle=%b expected 0110", {vld3, done3, ready3, idle3});
    end
    @(negedge clk);
    n_checks++;
    if ({vld3, done3, idle3} !== 3'b001) begin
      n_fail++; $display("FAIL single_idle: got vld/done/idle=%b expected 001", {vld3, done3, idle3});
    end
    ack3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_back_pressure();
    test_held_start();
    test_reset_mid_run();
    test_wrap();
    test_single_word();
    test_lfsr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
